muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_pkg.sv | 23 ++
 rtl/muldiv_datapath.sv | 54 +++++
 rtl/muldiv_sequencer.sv | 155 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - operation codes as seen on i_op
//   - FSM state encoding
//   - default operand/result width
package muldiv_sequencer_pkg;

    localparam int NB_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// One radix-2 iteration of the sequential multiplier / restoring divider.
// Purely combinational; the sequencer owns the accumulator registers.
// Ports:
//   i_is_div     : 1 = restoring divide step, 0 = shift-add multiply step
//   i_acc_hi     : multiply: running upper product half; divide: partial remainder
//   i_acc_lo     : multiply: multiplier being shifted out (low product fills in);
//                  divide: dividend being shifted out (quotient fills in)
//   i_operand_b  : multiplicand / divisor magnitude
//   o_acc_hi/lo  : accumulator values after this iteration
module muldiv_datapath #(
    parameter int NB = 32
) (
    input  logic          i_is_div,
    input  logic [NB-1:0] i_acc_hi,
    input  logic [NB-1:0] i_acc_lo,
    input  logic [NB-1:0] i_operand_b,
    output logic [NB-1:0] o_acc_hi,
    output logic [NB-1:0] o_acc_lo
);

    logic [NB-1:0] addend;
    logic [NB:0]   add_sum;
    logic [NB:0]   shifted;
    logic [NB:0]   diff;
    logic          borrow;
    logic          unused_diff_msb;

    // A successful trial subtraction always leaves a remainder below the
    // divisor, so the top difference bit is zero whenever it is kept.
    assign unused_diff_msb = diff[NB];

    always_comb begin
        addend            = i_acc_lo[0] ? i_operand_b : '0;
        add_sum           = {1'b0, i_acc_hi} + {1'b0, addend};
        shifted           = {i_acc_hi, i_acc_lo[NB-1]};
        {borrow, diff}    = {1'b0, shifted} - {2'b00, i_operand_b};
        o_acc_hi          = '0;
        o_acc_lo          = '0;
        if (i_is_div) begin
            if (!borrow) begin
                o_acc_hi = diff[NB-1:0];
                o_acc_lo = {i_acc_lo[NB-2:0], 1'b1};
            end else begin
                o_acc_hi = shifted[NB-1:0];
                o_acc_lo = {i_acc_lo[NB-2:0], 1'b0};
            end
        end else begin
            // Carry out of the add becomes the new MSB after the right shift.
            o_acc_hi = add_sum[NB:1];
            o_acc_lo = {add_sum[0], i_acc_lo[NB-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// An accepted start takes NB+2 cycles: NB iterations, one sign-fix cycle,
// then a DONE cycle in which o_done pulses and the new HI/LO are visible.
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_start, i_op         : launch request (IDLE only) and operation code
//   i_data_a, i_data_b    : rs / rt operands
//   i_mthi, i_mtlo        : direct writes of i_data_a into HI / LO (IDLE only)
//   i_flush               : abort in-flight op; suppresses IDLE requests
//   o_stall               : hold upstream pipeline registers
//   o_done                : one-cycle completion pulse
//   o_hi, o_lo            : architectural HI / LO
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int NB     = NB_DEFAULT,
    parameter int NB_CNT = 6
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [1:0]    i_op,
    input  logic [NB-1:0] i_data_a,
    input  logic [NB-1:0] i_data_b,
    input  logic          i_mthi,
    input  logic          i_mtlo,
    input  logic          i_flush,
    output logic          o_stall,
    output logic          o_done,
    output logic [NB-1:0] o_hi,
    output logic [NB-1:0] o_lo
);

    state_e            state, state_nxt;
    logic [NB_CNT-1:0] cnt;
    logic              accept, op_signed;
    logic              op_div, neg_main, neg_rem, div_zero;
    logic [NB-1:0]     a_raw, b_mag, acc_hi, acc_lo, step_hi, step_lo;
    logic [NB-1:0]     res_hi, res_lo, hi_q, lo_q;
    logic [2*NB-1:0]   product, product_fix;

    function automatic logic [NB-1:0] negate(input logic [NB-1:0] v);
        return ~v + NB'(1);
    endfunction

    function automatic logic [2*NB-1:0] negate_wide(input logic [2*NB-1:0] v);
        return ~v + (2*NB)'(1);
    endfunction

    function automatic logic [NB-1:0] magnitude(input logic signed [NB-1:0] v,
                                                input logic is_signed);
        return (is_signed && v[NB-1]) ? negate(v) : v;
    endfunction

    assign op_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign accept    = (state == ST_IDLE) && i_start && !i_flush;

    always_comb begin
        state_nxt = state;
        o_stall   = 1'b0;
        o_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                o_stall = i_start;
                if (accept) state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                o_stall = 1'b1;
                if (i_flush)                  state_nxt = ST_IDLE;
                else if (cnt == NB_CNT'(1))   state_nxt = ST_FIX;
            end
            ST_FIX: begin
                o_stall   = 1'b1;
                state_nxt = i_flush ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                o_stall   = 1'b1;
                o_done    = !i_flush;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept)                cnt <= NB_CNT'(NB);
            else if (state == ST_BUSY) cnt <= cnt - NB_CNT'(1);
        end
    end

    // HI/LO: completed op wins in DONE; moves only when idle and unrequested.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == ST_DONE) begin
            if (!i_flush) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else if (state == ST_IDLE && !i_start && !i_flush) begin
            if (i_mthi) hi_q <= i_data_a;
            if (i_mtlo) lo_q <= i_data_a;
        end
    end

    // Operand latch / iteration / sign fix (data only, no reset)
    always_ff @(posedge i_clk) begin
        if (accept) begin
            op_div   <= i_op[1];
            a_raw    <= i_data_a;
            acc_hi   <= '0;
            acc_lo   <= magnitude(i_data_a, op_signed);
            b_mag    <= magnitude(i_data_b, op_signed);
            neg_main <= op_signed && (i_data_a[NB-1] ^ i_data_b[NB-1]);
            neg_rem  <= op_signed && i_data_a[NB-1];
            div_zero <= i_op[1] && (i_data_b == '0);
        end else if (state == ST_BUSY) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end else if (state == ST_FIX) begin
            if (!op_div) begin
                {res_hi, res_lo} <= product_fix;
            end else if (div_zero) begin
                res_hi <= a_raw;
                res_lo <= '1;
            end else begin
                res_hi <= neg_rem  ? negate(acc_hi) : acc_hi;
                res_lo <= neg_main ? negate(acc_lo) : acc_lo;
            end
        end
    end

    assign product     = {acc_hi, acc_lo};
    assign product_fix = neg_main ? negate_wide(product) : product;

    muldiv_datapath #(.NB(NB)) u_datapath (
        .i_is_div    (op_div),
        .i_acc_hi    (acc_hi),
        .i_acc_lo    (acc_lo),
        .i_operand_b (b_mag),
        .o_acc_hi    (step_hi),
        .o_acc_lo    (step_lo)
    );

    // During DONE the fresh result is forwarded so it is visible that cycle.
    assign o_hi = o_done ? res_hi : hi_q;
    assign o_lo = o_done ? res_lo : lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer (NB = 32).
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    localparam int NB = 32;

    logic          clk = 1'b0;
    logic          reset, start, mthi, mtlo, flush;
    logic [1:0]    op;
    logic [NB-1:0] data_a, data_b;
    logic          stall, done;
    logic [NB-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    muldiv_sequencer #(.NB(NB), .NB_CNT(6)) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_start  (start),
        .i_op     (op),
        .i_data_a (data_a),
        .i_data_b (data_b),
        .i_mthi   (mthi),
        .i_mtlo   (mtlo),
        .i_flush  (flush),
        .o_stall  (stall),
        .o_done   (done),
        .o_hi     (hi),
        .o_lo     (lo)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definition.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a,
                                      input logic [31:0] b,
                                      output logic [31:0] rh, output logic [31:0] rl);
        longint sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rh = '0;
        rl = '0;
        case (o)
            2'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
            2'd1: begin up = {32'd0, a} * {32'd0, b}; rh = up[63:32]; rl = up[31:0]; end
            2'd2: begin
                if (b == 0) begin rh = a; rl = '1; end
                else begin q = sa / sb; r = sa % sb; rh = r[31:0]; rl = q[31:0]; end
            end
            default: begin
                if (b == 0) begin rh = a; rl = '1; end
                else begin rh = a % b; rl = a / b; end
            end
        endcase
    endfunction

    // Launch an op in the current cycle (cycle 0) and check the full timeline.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int stall_bad, early;
        stall_bad = 0;
        early     = 0;
        start = 1'b1; op = o; data_a = a; data_b = b;
        #1;
        chk({nm, " stall_req"}, 64'(stall), 64'd1);
        for (int c = 1; c <= NB + 2; c++) begin
            step();
            start  = 1'b0;
            data_a = $urandom;
            data_b = $urandom;
            #1;
            if (!stall) stall_bad++;
            if (c < NB + 2 && done) early++;
        end
        chk({nm, " done"}, 64'(done), 64'd1);
        chk({nm, " hi"}, 64'(hi), 64'(eh));
        chk({nm, " lo"}, 64'(lo), 64'(el));
        chk({nm, " stall_busy"}, 64'(stall_bad), 64'd0);
        chk({nm, " early_done"}, 64'(early), 64'd0);
        step();
        data_a = '0;
        data_b = '0;
        #1;
        chk({nm, " done_pulse"}, 64'(done), 64'd0);
        chk({nm, " stall_off"}, 64'(stall), 64'd0);
        chk({nm, " hi_hold"}, 64'(hi), 64'(eh));
        chk({nm, " lo_hold"}, 64'(lo), 64'(el));
    endtask

    initial begin
        logic [31:0] eh, el, ra, rb;
        logic [1:0]  ro;
        int          bad;

        vecs[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'd3, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
        vecs[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{2'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[6] = '{2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[7] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9] = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14};

        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
        op = 2'd0; data_a = '0; data_b = '0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset stall", 64'(stall), 64'd0);

        // Directed vector table
        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo);

        // Randomized ops against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                default: rb = $urandom;
            endcase
            ref_model(ro, ra, rb, eh, el);
            run_op($sformatf("rnd%0d op%0d", i, ro), ro, ra, rb, eh, el);
        end

        // mthi and mtlo together, then flushed DIVU with a stray start
        mthi = 1'b1; mtlo = 1'b1; data_a = 32'hAAAA5555;
        step();
        mthi = 1'b0; mtlo = 1'b0;
        #1;
        chk("mthilo hi", 64'(hi), 64'hAAAA5555);
        chk("mthilo lo", 64'(lo), 64'hAAAA5555);
        start = 1'b1; op = 2'd3; data_a = 32'd1000; data_b = 32'd3;
        #1;
        bad = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            start = (c == 5);
            op    = (c == 5) ? 2'd0 : 2'd3;
            flush = (c == 10);
            #1;
            if (done) bad++;
            if (!stall) bad++;
        end
        step();
        start = 1'b0; flush = 1'b0;
        #1;
        chk("flush idle_stall", 64'(stall), 64'd0);
        for (int c = 0; c < 40; c++) begin
            if (done || stall) bad++;
            step();
        end
        chk("flush no_done", 64'(bad), 64'd0);
        chk("flush hi", 64'(hi), 64'hAAAA5555);
        chk("flush lo", 64'(lo), 64'hAAAA5555);

        // mthi in IDLE; mtlo ignored under flush and during BUSY
        mthi = 1'b1; data_a = 32'h12345678;
        step();
        mthi = 1'b0;
        #1;
        chk("mthi hi", 64'(hi), 64'h12345678);
        mtlo = 1'b1; flush = 1'b1; data_a = 32'h01010101;
        step();
        mtlo = 1'b0; flush = 1'b0;
        #1;
        chk("mtlo flushed", 64'(lo), 64'hAAAA5555);
        start = 1'b1; mtlo = 1'b1; op = 2'd1; data_a = 32'd2; data_b = 32'd3;
        #1;
        for (int c = 1; c <= NB + 2; c++) begin
            step();
            start = 1'b0;
            mtlo  = (c == 3);
            data_a = 32'hDEADBEEF;
            #1;
            if (c == 4) chk("mtlo busy", 64'(lo), 64'hAAAA5555);
        end
        chk("mtlo op done", 64'(done), 64'd1);
        chk("mtlo op hi", 64'(hi), 64'd0);
        chk("mtlo op lo", 64'(lo), 64'd6);
        step();

        // Reset mid-MULT, asserted together with a start request
        mthi = 1'b1; data_a = 32'h0BADF00D;
        step();
        mthi = 1'b0;
        start = 1'b1; op = 2'd0; data_a = 32'hFFFFFFFD; data_b = 32'd7;
        #1;
        for (int c = 1; c <= 20; c++) begin
            step();
            start = (c == 20);
            reset = (c == 20);
        end
        step();
        start = 1'b0; reset = 1'b0;
        #1;
        chk("rst stall", 64'(stall), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || stall) bad++;
            step();
        end
        chk("rst quiet", 64'(bad), 64'd0);
        run_op("post_rst", 2'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
